cache_axi_rd_bridge: RTL

Responder end of the cache refill interface (rd_req/rd_type/rd_addr in, rd_rdy/ret_valid/ret_last/ret_data out). It converts each accepted cache read request into one AXI4 read burst and streams the R beats back to the cache, low 64-bit half of a line first. It sits between the I-cache and the AXI4 crossbar/memory, with one transaction outstanding at a time.

---
 rtl/cache_axi_rd_bridge_pkg.sv | 25 ++
 rtl/cache_axi_rd_bridge_ar_gen.sv | 40 ++++
 rtl/cache_axi_rd_bridge.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cache_axi_rd_bridge_pkg.sv
// Shared definitions for the cache refill to AXI4 read bridge:
// rd_type encodings, AXI burst/response constants and the FSM state type.
// Optional build macro used by the bridge: CACHE_AXI_RD_BRIDGE_RESP_CHK_EN.
package cache_axi_rd_bridge_pkg;

    // Cache read request sizes
    localparam logic [2:0] RD_BYTE  = 3'b000;
    localparam logic [2:0] RD_HALF  = 3'b001;
    localparam logic [2:0] RD_WORD  = 3'b010;
    localparam logic [2:0] RD_DWORD = 3'b011;
    localparam logic [2:0] RD_LINE  = 3'b100;

    // AXI constants
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

    // Bridge FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

endpackage

// File: rtl/cache_axi_rd_bridge_ar_gen.sv
// Combinational mapping of a cache read request (rd_type/rd_addr) onto the
// AXI AR fields araddr/arlen/arsize. Line requests are aligned to the line
// and fetched as a 2-beat burst of 8-byte beats; all other sizes are a
// single beat at the request address. Reserved types fetch a dword.
module cache_axi_rd_bridge_ar_gen
    import cache_axi_rd_bridge_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic [2:0]        rd_type,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

    // Size decode: line -> aligned 2-beat burst, reserved -> dword
    always_comb begin
        araddr = rd_addr;
        arlen  = 8'd0;
        arsize = AXI_SIZE_8B;
        case (rd_type)
            RD_BYTE, RD_HALF, RD_WORD, RD_DWORD: begin
                arsize = {1'b0, rd_type[1:0]};
            end
            RD_LINE: begin
                araddr = rd_addr & LINE_MASK;
                arlen  = 8'd1;
                arsize = AXI_SIZE_8B;
            end
            default: begin
                arsize = AXI_SIZE_8B;
            end
        endcase
    end

endmodule

// File: rtl/cache_axi_rd_bridge.sv
// Cache refill responder: turns each accepted cache read request into one
// AXI4 INCR read burst and forwards the R beats back, one per cycle, with
// ret_last derived from the beat counter (rlast is not trusted).
// Handshakes: a request is taken when rd_req=1 while rd_rdy=1; AR completes
// on arvalid&arready; an R beat is taken on rvalid&rready; ret_valid is a
// single-cycle pulse with no backpressure.
// Optional macro CACHE_AXI_RD_BRIDGE_RESP_CHK_EN adds ret_err, flagging
// beats with a non-OKAY rresp or an rlast that disagrees with the counter.
module cache_axi_rd_bridge
    import cache_axi_rd_bridge_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 64,
    parameter int         LINE_BYTES = 16,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [2:0]        rd_type,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [DATA_W-1:0] ret_data,
`ifdef CACHE_AXI_RD_BRIDGE_RESP_CHK_EN
    output logic              ret_err,
`endif
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [3:0]        arid,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic [1:0]        rresp
);

    state_t            state;
    logic [7:0]        beat_cnt;
    logic              beat_last;
    logic [ADDR_W-1:0] gen_araddr;
    logic [7:0]        gen_arlen;
    logic [2:0]        gen_arsize;

    assign arburst   = AXI_BURST_INCR;
    assign arid      = AXI_ID;
    assign beat_last = (beat_cnt == arlen);

`ifndef CACHE_AXI_RD_BRIDGE_RESP_CHK_EN
    // Response status is not inspected in this build
    logic unused_resp;
    assign unused_resp = ^{rresp, rlast};
`endif

    cache_axi_rd_bridge_ar_gen #(
        .ADDR_W     (ADDR_W),
        .LINE_BYTES (LINE_BYTES)
    ) u_ar_gen (
        .rd_type (rd_type),
        .rd_addr (rd_addr),
        .araddr  (gen_araddr),
        .arlen   (gen_arlen),
        .arsize  (gen_arsize)
    );

    // Request/AR/R sequencing with all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_rdy    <= 1'b1;
            ret_valid <= 1'b0;
            ret_last  <= 1'b0;
            ret_data  <= '0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
            rready    <= 1'b0;
            beat_cnt  <= '0;
`ifdef CACHE_AXI_RD_BRIDGE_RESP_CHK_EN
            ret_err   <= 1'b0;
`endif
        end else begin
            // Return strobes are pulses; only a captured beat raises them
            ret_valid <= 1'b0;
            ret_last  <= 1'b0;
`ifdef CACHE_AXI_RD_BRIDGE_RESP_CHK_EN
            ret_err   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        araddr  <= gen_araddr;
                        arlen   <= gen_arlen;
                        arsize  <= gen_arsize;
                        rd_rdy  <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (arvalid && arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        beat_cnt <= 8'd0;
                        state    <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid && rready) begin
                        ret_valid <= 1'b1;
                        ret_data  <= rdata;
                        ret_last  <= beat_last;
                        beat_cnt  <= beat_cnt + 8'd1;
`ifdef CACHE_AXI_RD_BRIDGE_RESP_CHK_EN
                        ret_err   <= (rresp != AXI_RESP_OKAY) || (rlast != beat_last);
`endif
                        if (beat_last) begin
                            rready <= 1'b0;
                            rd_rdy <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
